// File: rtl/phase_diff_slicer_pkg.sv
// Shared types and width helper for the phase-difference bit slicer.
package cdr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    ACC   = 2'd2
  } slicer_state_t;

  typedef enum logic {
    MODE_SAMPLE = 1'b0,
    MODE_INTEG  = 1'b1
  } slicer_mode_t;

  // Accumulator width: room for SPS full-scale differences.
  function automatic int unsigned acc_width(int unsigned ph_w, int unsigned sps);
    return ph_w + $clog2(sps);
  endfunction

endpackage

// File: rtl/phase_diff_slicer_if.sv
// Phase stream in, decided bits out, for the phase-difference slicer.
interface phase_diff_slicer_if
  import cdr_pkg::*;
#(
  parameter int PH_W = 6,
  parameter int SPS  = 4
);
  localparam int ACC_W = acc_width(PH_W, SPS);

  logic signed [PH_W-1:0]  phase;
  logic                    ph_valid;
  logic                    sym_sync;
  logic                    mode;
  logic                    bit_valid;
  logic                    bit_data;
  logic signed [ACC_W-1:0] bit_soft;
  logic                    bit_erase;
  logic                    busy;

  modport master (
    output phase, ph_valid, sym_sync, mode,
    input  bit_valid, bit_data, bit_soft, bit_erase, busy
  );

  modport slave (
    input  phase, ph_valid, sym_sync, mode,
    output bit_valid, bit_data, bit_soft, bit_erase, busy
  );

endinterface

// File: rtl/phase_diff_slicer_integrator.sv
// Previous-phase register, wrapping difference, window accumulator and
// window-end / realignment logic.
module phase_integrator
  import cdr_pkg::*;
#(
  parameter int PH_W = 6,
  parameter int SPS  = 4,
  localparam int ACC_W = acc_width(PH_W, SPS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [PH_W-1:0]  phase_i,
  input  logic                    load_i,    // priming sample: capture reference only
  input  logic                    step_i,    // valid sample that forms a difference
  input  logic                    sync_i,    // realign window on this sample
  input  logic                    integ_i,   // 1 = integrate over SPS samples
  input  logic                    flush_i,   // discard partial window
  output logic                    win_end_o,
  output logic signed [ACC_W-1:0] sum_o
);

  localparam int CNT_W = $clog2(SPS);

  logic signed [PH_W-1:0]  ph_prev_q, ph_prev_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [PH_W-1:0]  diff;
  logic signed [ACC_W-1:0] diff_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    last;

  // Difference, window sum and next accumulator state.
  always_comb begin
    ph_prev_d = ph_prev_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;

    // PH_W-bit wraparound performs the modulo-2pi correction.
    diff      = phase_i - ph_prev_q;
    diff_ext  = {{(ACC_W-PH_W){diff[PH_W-1]}}, diff};
    sum       = acc_q + diff_ext;
    last      = integ_i ? (cnt_q == CNT_W'(SPS-1)) : 1'b1;
    // Realignment suppresses a coincident window end.
    win_end_o = step_i && !sync_i && last;
    sum_o     = sum;

    if (load_i) begin
      ph_prev_d = phase_i;
      acc_d     = '0;
      cnt_d     = '0;
    end else if (step_i) begin
      ph_prev_d = phase_i;
      if (sync_i) begin
        acc_d = diff_ext;
        cnt_d = CNT_W'(1);
      end else if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end else if (flush_i) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  // Integrator state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_prev_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      ph_prev_q <= ph_prev_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/phase_diff_slicer.sv
// CDR bit recovery: sequences the phase stream through IDLE/PRIME/ACC and
// slices each completed window into hard bit, soft sum and erasure flag.
module phase_diff_slicer
  import cdr_pkg::*;
#(
  parameter int PH_W = 6,
  parameter int SPS  = 4,
  parameter int HYST = 2
) (
  input  logic              clk,
  input  logic              reset,
  phase_diff_slicer_if.slave bus
);

  localparam int ACC_W = acc_width(PH_W, SPS);
  localparam logic signed [ACC_W-1:0] HYST_POS = ACC_W'(HYST);
  localparam logic signed [ACC_W-1:0] HYST_NEG = -HYST_POS;

  slicer_state_t state_q, state_d;
  slicer_mode_t  mode_q, mode_d;

  logic load, step, sync, flush;
  logic win_end;
  logic signed [ACC_W-1:0] sum;
  logic in_zone;

  logic                    bit_valid_q, bit_valid_d;
  logic                    bit_data_q, bit_data_d;
  logic signed [ACC_W-1:0] bit_soft_q, bit_soft_d;
  logic                    bit_erase_q, bit_erase_d;

  phase_integrator #(
    .PH_W (PH_W),
    .SPS  (SPS)
  ) u_integ (
    .clk       (clk),
    .reset     (reset),
    .phase_i   (bus.phase),
    .load_i    (load),
    .step_i    (step),
    .sync_i    (sync),
    .integ_i   (mode_q == MODE_INTEG),
    .flush_i   (flush),
    .win_end_o (win_end),
    .sum_o     (sum)
  );

  // Next state and integrator controls.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    load    = 1'b0;
    step    = 1'b0;
    sync    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ph_valid) begin
          state_d = PRIME;
          mode_d  = slicer_mode_t'(bus.mode);
          load    = 1'b1;
        end
      end
      PRIME: begin
        if (bus.ph_valid) begin
          state_d = ACC;
          step    = 1'b1;
        end else begin
          state_d = IDLE;
          flush   = 1'b1;
        end
      end
      ACC: begin
        if (bus.ph_valid) begin
          step = 1'b1;
          sync = bus.sym_sync;
        end else begin
          state_d = IDLE;
          flush   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        flush   = 1'b1;
      end
    endcase
  end

  // State and latched mode registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_SAMPLE;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Slicer decision: dead zone holds the previous hard bit.
  always_comb begin
    in_zone     = (sum >= HYST_NEG) && (sum <= HYST_POS);
    bit_valid_d = win_end;
    bit_data_d  = bit_data_q;
    bit_soft_d  = bit_soft_q;
    bit_erase_d = bit_erase_q;
    if (win_end) begin
      bit_soft_d  = sum;
      bit_erase_d = in_zone;
      if (!in_zone) begin
        bit_data_d = ~sum[ACC_W-1];
      end
    end
  end

  // Registered slicer outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_valid_q <= 1'b0;
      bit_data_q  <= 1'b0;
      bit_soft_q  <= '0;
      bit_erase_q <= 1'b0;
    end else begin
      bit_valid_q <= bit_valid_d;
      bit_data_q  <= bit_data_d;
      bit_soft_q  <= bit_soft_d;
      bit_erase_q <= bit_erase_d;
    end
  end

  // Drive the bus outputs.
  always_comb begin
    bus.bit_valid = bit_valid_q;
    bus.bit_data  = bit_data_q;
    bus.bit_soft  = bit_soft_q;
    bus.bit_erase = bit_erase_q;
    bus.busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_phase_diff_slicer.sv
// Bench for phase_diff_slicer: directed vector table plus random stimulus
// against a queue-based window model.
module tb_phase_diff_slicer;

  localparam int PH_W = 6;
  localparam int SPS  = 4;
  localparam int HYST = 2;
  localparam int PH_M = 1 << PH_W;

  typedef struct {
    bit rst;
    bit vld;
    bit sync;
    bit mode;
    int ph;
    bit ev;
    bit ed;
    int es;
    bit ee;
    bit eb;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  phase_diff_slicer_if #(.PH_W(PH_W), .SPS(SPS)) bus ();

  phase_diff_slicer #(
    .PH_W (PH_W),
    .SPS  (SPS),
    .HYST (HYST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit rst, bit vld, bit sync, bit mode, int ph,
                              bit ev, bit ed, int es, bit ee, bit eb);
    vec_t r;
    r.rst = rst; r.vld = vld; r.sync = sync; r.mode = mode; r.ph = ph;
    r.ev = ev; r.ed = ed; r.es = es; r.ee = ee; r.eb = eb;
    return r;
  endfunction

  function automatic int wrapd(int a, int b);
    int d;
    d = (((a - b) % PH_M) + PH_M) % PH_M;
    if (d >= PH_M / 2) d = d - PH_M;
    return d;
  endfunction

  task automatic apply(bit r, bit v, bit s, bit m, int ph);
    reset        = r;
    bus.ph_valid = v;
    bus.sym_sync = s;
    bus.mode     = m;
    bus.phase    = PH_W'(ph);
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(int idx, bit ev, bit ed, int es, bit ee, bit eb);
    check("bit_valid", idx, int'(bus.bit_valid), int'(ev));
    check("bit_data",  idx, int'(bus.bit_data),  int'(ed));
    check("bit_soft",  idx, int'($signed(bus.bit_soft)), es);
    check("bit_erase", idx, int'(bus.bit_erase), int'(ee));
    check("busy",      idx, int'(bus.busy),      int'(eb));
  endtask

  vec_t tbl[$];

  // Reference model state
  bit m_active, m_first, m_mode;
  int m_prev;
  int win[$];
  bit m_valid, m_data, m_erase;
  int m_soft;

  initial begin
    int d, sum;
    bit r, v, s, m;
    int ph;

    reset = 1'b1;
    bus.ph_valid = 1'b0;
    bus.sym_sync = 1'b0;
    bus.mode = 1'b0;
    bus.phase = '0;

    // rst vld sync mode phase | valid data soft erase busy
    tbl.push_back(mk(1,0,0,0,  0, 0,0,  0,0,0));
    // T1: per-sample, +8 steps
    tbl.push_back(mk(0,1,0,0,  0, 0,0,  0,0,1));
    tbl.push_back(mk(0,1,0,0,  8, 1,1,  8,0,1));
    tbl.push_back(mk(0,1,0,0, 16, 1,1,  8,0,1));
    tbl.push_back(mk(0,1,0,0, 24, 1,1,  8,0,1));
    tbl.push_back(mk(0,0,0,0,  0, 0,1,  8,0,0));
    // T3: integrate, +4 steps
    tbl.push_back(mk(0,1,0,1,  0, 0,1,  8,0,1));
    tbl.push_back(mk(0,1,0,1,  4, 0,1,  8,0,1));
    tbl.push_back(mk(0,1,0,1,  8, 0,1,  8,0,1));
    tbl.push_back(mk(0,1,0,1, 12, 0,1,  8,0,1));
    tbl.push_back(mk(0,1,0,1, 16, 1,1, 16,0,1));
    tbl.push_back(mk(0,0,0,1,  0, 0,1, 16,0,0));
    // T2: wraparound, per-sample
    tbl.push_back(mk(0,1,0,0, 28, 0,1, 16,0,1));
    tbl.push_back(mk(0,1,0,0,-28, 1,1,  8,0,1));
    tbl.push_back(mk(0,1,0,0, 28, 1,0, -8,0,1));
    tbl.push_back(mk(0,0,0,0,  0, 0,0, -8,0,0));
    // T4: dead zone, prior bit 0
    tbl.push_back(mk(0,1,0,1,  0, 0,0, -8,0,1));
    tbl.push_back(mk(0,1,0,1,  1, 0,0, -8,0,1));
    tbl.push_back(mk(0,1,0,1,  0, 0,0, -8,0,1));
    tbl.push_back(mk(0,1,0,1,  1, 0,0, -8,0,1));
    tbl.push_back(mk(0,1,0,1,  2, 1,0,  2,1,1));
    tbl.push_back(mk(0,0,0,1,  0, 0,0,  2,1,0));
    // T5: drop after two diffs, then a clean window
    tbl.push_back(mk(0,1,0,1,  0, 0,0,  2,1,1));
    tbl.push_back(mk(0,1,0,1, 10, 0,0,  2,1,1));
    tbl.push_back(mk(0,1,0,1, 20, 0,0,  2,1,1));
    tbl.push_back(mk(0,0,0,1,  0, 0,0,  2,1,0));
    tbl.push_back(mk(0,1,0,1,  0, 0,0,  2,1,1));
    tbl.push_back(mk(0,1,0,1, -5, 0,0,  2,1,1));
    tbl.push_back(mk(0,1,0,1,-10, 0,0,  2,1,1));
    tbl.push_back(mk(0,1,0,1,-15, 0,0,  2,1,1));
    tbl.push_back(mk(0,1,0,1,-20, 1,0,-20,0,1));
    tbl.push_back(mk(0,0,0,1,  0, 0,0,-20,0,0));
    // T6: sym_sync on third diff, then reset mid-window
    tbl.push_back(mk(0,1,0,1,  0, 0,0,-20,0,1));
    tbl.push_back(mk(0,1,0,1,  8, 0,0,-20,0,1));
    tbl.push_back(mk(0,1,0,1, 16, 0,0,-20,0,1));
    tbl.push_back(mk(0,1,1,1,  8, 0,0,-20,0,1));
    tbl.push_back(mk(0,1,0,1,  0, 0,0,-20,0,1));
    tbl.push_back(mk(0,1,0,1, -8, 0,0,-20,0,1));
    tbl.push_back(mk(0,1,0,1,-16, 1,0,-32,0,1));
    tbl.push_back(mk(0,1,0,1, -8, 0,0,-32,0,1));
    tbl.push_back(mk(0,1,0,1,  0, 0,0,-32,0,1));
    tbl.push_back(mk(1,1,0,1,  8, 0,0,  0,0,0));
    // sym_sync coincident with window end: realignment wins
    tbl.push_back(mk(0,1,0,1,  0, 0,0,  0,0,1));
    tbl.push_back(mk(0,1,0,1,  1, 0,0,  0,0,1));
    tbl.push_back(mk(0,1,0,1,  2, 0,0,  0,0,1));
    tbl.push_back(mk(0,1,0,1,  3, 0,0,  0,0,1));
    tbl.push_back(mk(0,1,1,1,  4, 0,0,  0,0,1));
    tbl.push_back(mk(0,1,0,1,  5, 0,0,  0,0,1));
    tbl.push_back(mk(0,1,0,1,  6, 0,0,  0,0,1));
    tbl.push_back(mk(0,1,0,1,  7, 1,1,  4,0,1));
    tbl.push_back(mk(0,0,0,1,  0, 0,1,  4,0,0));

    @(negedge clk);
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].vld, tbl[i].sync, tbl[i].mode, tbl[i].ph);
      check_all(i, tbl[i].ev, tbl[i].ed, tbl[i].es, tbl[i].ee, tbl[i].eb);
    end

    // Random phase: reset first, then model every cycle.
    apply(1, 0, 0, 0, 0);
    m_active = 0; m_first = 0; m_mode = 0; m_prev = 0;
    m_valid = 0; m_data = 0; m_erase = 0; m_soft = 0;
    win.delete();
    check_all(1000, 0, 0, 0, 0, 0);

    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 99) < 1);
      v  = ($urandom_range(0, 99) < 88);
      s  = ($urandom_range(0, 99) < 12);
      m  = ($urandom_range(0, 99) < 60);
      ph = int'($urandom_range(0, PH_M - 1)) - PH_M / 2;
      apply(r, v, s, m, ph);

      m_valid = 0;
      if (r) begin
        m_active = 0; m_data = 0; m_soft = 0; m_erase = 0;
        win.delete();
      end else if (!v) begin
        m_active = 0;
        win.delete();
      end else if (!m_active) begin
        m_active = 1; m_first = 1; m_prev = ph; m_mode = m;
        win.delete();
      end else begin
        d = wrapd(ph, m_prev);
        m_prev = ph;
        if (s && !m_first) begin
          win.delete();
          win.push_back(d);
        end else begin
          win.push_back(d);
          if (!m_mode || win.size() == SPS) begin
            sum = win.sum();
            win.delete();
            m_valid = 1;
            m_soft = sum;
            if (sum >= -HYST && sum <= HYST) begin
              m_erase = 1;
            end else begin
              m_erase = 0;
              m_data = (sum > 0);
            end
          end
        end
        m_first = 0;
      end
      check_all(2000 + c, m_valid, m_data, m_soft, m_erase, m_active);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
